// File: rtl/mult_seq_if.sv
// Request/result bus between a multicycle controller and the shift-add multiplier.
// The controller owns the master side; mult_seq owns the slave side.
interface mult_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output hi,
        output lo
    );
endinterface

// File: rtl/mult_seq.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH iterative shift-add multiplier (MIPS multu into HI/LO).
// Borrows the shared combinational ALU as its adder: one partial-product add per clock.
module mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    mult_seq_if.slave        bus,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_out
);
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned LAST_IT  = 31;
    localparam logic [3:0]  ALU_AND  = 4'b0000;
    localparam logic [3:0]  ALU_ADD  = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [WIDTH-1:0]   hi, hi_n;
    logic [WIDTH-1:0]   lo, lo_n;
    logic [CNT_W-1:0]   count, count_n;
    logic               busy, busy_n;
    logic               done, done_n;
    logic               carry;

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            mcand <= mcand_n;
            hi    <= hi_n;
            lo    <= lo_n;
            count <= count_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state, register updates and ALU drive.
    always_comb begin
        state_n       = state;
        mcand_n       = mcand;
        hi_n          = hi;
        lo_n          = lo;
        count_n       = count;
        busy_n        = 1'b0;
        done_n        = 1'b0;
        alu_in0       = '0;
        alu_in1       = '0;
        alu_operation = ALU_AND;
        carry         = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    mcand_n = bus.multiplicand;
                    hi_n    = '0;
                    lo_n    = bus.multiplier;
                    count_n = '0;
                    state_n = RUN;
                    busy_n  = 1'b1;
                end
            end

            RUN: begin
                alu_operation = ALU_ADD;
                alu_in0       = hi;
                alu_in1       = lo[0] ? mcand : '0;
                // Adder wrapped iff the sum is below an addend; no add means no carry.
                carry         = lo[0] & (alu_out < hi);
                hi_n          = {carry, alu_out[WIDTH-1:1]};
                lo_n          = {alu_out[0], lo[WIDTH-1:1]};
                count_n       = count + CNT_W'(1);
                busy_n        = 1'b1;
                if (count == CNT_W'(LAST_IT)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: scoreboard of expected products, behavioural ALU stub.
module tb_mult_seq;
    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = 32;   // accept edge to the edge after which done is high
    localparam int          PERIOD_EDGES = 34;  // done-to-done with earliest restart

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] alu_in0;
    logic [WIDTH-1:0] alu_in1;
    logic [3:0]       alu_operation;
    logic [WIDTH-1:0] alu_out;

    mult_seq_if #(.WIDTH(WIDTH)) bus ();

    mult_seq #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus.slave),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_operation (alu_operation),
        .alu_out       (alu_out)
    );

    // Stand-in for the datapath ALU.
    always_comb begin
        case (alu_operation)
            4'b0000: alu_out = alu_in0 & alu_in1;
            4'b0001: alu_out = alu_in0 | alu_in1;
            4'b0010: alu_out = alu_in0 + alu_in1;
            4'b0110: alu_out = alu_in0 - alu_in1;
            default: alu_out = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc++;
        if (bus.done) done_cnt++;
    end

    int total = 0;
    int bad   = 0;
    logic [63:0] expq[$];
    int acc_edge;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive a request and hold start until the DUT accepts it (busy rises).
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic pb;
        bit   ok;
        pb = bus.busy;
        ok = 1'b0;
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.busy && !pb) begin
                ok = 1'b1;
                break;
            end
            pb = bus.busy;
        end
        bus.start = 1'b0;
        if (!ok) check("accept", {63'b0, bus.busy}, 64'd1);
        acc_edge = cyc;
        expq.push_back({32'b0, a} * {32'b0, b});
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) check("done_timeout", {63'b0, bus.done}, 64'd1);
    endtask

    task automatic sb_compare(input string tag);
        logic [63:0] e;
        if (expq.size() == 0) begin
            check({tag, "_sb_depth"}, 64'(expq.size()), 64'd1);
        end else begin
            e = expq.pop_front();
            check(tag, {bus.hi, bus.lo}, e);
        end
    endtask

    task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int d;
        int a_e;
        launch(a, b);
        a_e = acc_edge;
        wait_done(d);
        sb_compare(tag);
        check({tag, "_lat"}, 64'(d - a_e), 64'(LAT));
        @(posedge clk); #1;
        check({tag, "_pulse"}, {63'b0, bus.done}, 64'd0);
    endtask

    initial begin
        int d;
        int prev;
        int dc0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        reset_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_aluop", 64'(alu_operation), 64'd0);
        check("rst_alu_in", {alu_in0, alu_in1}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 3 x 5, with a look at the first RUN cycle's ALU drive
        launch(32'd3, 32'd5);
        check("run_busy", {63'b0, bus.busy}, 64'd1);
        check("run_aluop", 64'(alu_operation), 64'd2);
        check("run_alu_in1", 64'(alu_in1), 64'd3);
        begin
            int a_e;
            a_e = acc_edge;
            wait_done(d);
            sb_compare("m3x5");
            check("m3x5_lat", 64'(d - a_e), 64'(LAT));
            check("m3x5_done_busy", {63'b0, bus.busy}, 64'd1);
            check("m3x5_done_aluop", 64'(alu_operation), 64'd0);
            @(posedge clk); #1;
            check("m3x5_pulse", {63'b0, bus.done}, 64'd0);
            check("m3x5_idle_busy", {63'b0, bus.busy}, 64'd0);
        end

        run_one("mffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_one("m8000x2", 32'h8000_0000, 32'd2);
        run_one("m0", 32'd0, 32'h1234_5678);
        run_one("mbx0", 32'hDEAD_BEEF, 32'd0);

        // Start pulses during RUN and DONE are ignored
        dc0 = done_cnt;
        launch(32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.multiplicand = 32'd1; bus.multiplier = 32'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(d);
        sb_compare("m7x9");
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("m7x9_pulse", {63'b0, bus.done}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("m7x9_ndone", 64'(done_cnt - dc0), 64'd1);
        check("m7x9_idle", {63'b0, bus.busy}, 64'd0);
        check("m7x9_hold", {bus.hi, bus.lo}, 64'd63);

        // Reset in the middle of 6 x 6
        launch(32'd6, 32'd6);
        repeat (15) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy", {63'b0, bus.busy}, 64'd0);
        check("mrst_done", {63'b0, bus.done}, 64'd0);
        check("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("mrst_aluop", 64'(alu_operation), 64'd0);
        expq.delete();
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_one("m2x4", 32'd2, 32'd4);

        // Back-to-back multiplies, each restarted as early as allowed
        prev = -1;
        launch($urandom, $urandom);
        for (int k = 0; k < 5; k++) begin
            wait_done(d);
            sb_compare("tput");
            if (k > 0) check("tput_gap", 64'(d - prev), 64'(PERIOD_EDGES));
            prev = d;
            if (k == 0)      launch(32'hFFFF_FFFF, $urandom);
            else if (k < 4)  launch($urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
